// File: rtl/register_list_formatter.sv
// Register-list text formatter: turns up to three 5-bit register numbers
// into an ASCII stream such as "r05,r17,r31 ", one byte per handshake.
module register_list_formatter #(
   parameter logic [7:0] SEPARATOR  = 8'h2C,
   parameter logic [7:0] TERMINATOR = 8'h20,
   parameter bit         UPPERCASE  = 1'b0
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start_in,
   input  logic [1:0] reg_count_in,
   input  logic [4:0] reg0_in,
   input  logic [4:0] reg1_in,
   input  logic [4:0] reg2_in,
   output logic       char_valid_out,
   output logic [7:0] char_out,
   input  logic       char_ready_in,
   output logic       busy_out,
   output logic       done_out,
   output logic       error_out
);

   localparam logic [7:0] PREFIX_CH = UPPERCASE ? 8'h52 : 8'h72;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFIX,
      S_TENS,
      S_ONES,
      S_SEP,
      S_TERM
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [1:0] cnt_q, cnt_d;
   logic [4:0] r0_q, r0_d;
   logic [4:0] r1_q, r1_d;
   logic [4:0] r2_q, r2_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic       xfer;
   logic       more;
   logic [4:0] cur;
   logic [1:0] tens;
   logic [4:0] tens_x10;
   logic [3:0] ones;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= 2'd0;
         r0_q    <= 5'd0;
         r1_q    <= 5'd0;
         r2_q    <= 5'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      cur = r2_q;
      unique case (idx_q)
         2'd0:    cur = r0_q;
         2'd1:    cur = r1_q;
         default: cur = r2_q;
      endcase
   end

   // Decimal split of a 0..31 value without a divider.
   always_comb begin
      tens     = 2'd0;
      tens_x10 = 5'd0;
      unique case (1'b1)
         (cur >= 5'd30): begin
            tens     = 2'd3;
            tens_x10 = 5'd30;
         end
         (cur >= 5'd20 && cur < 5'd30): begin
            tens     = 2'd2;
            tens_x10 = 5'd20;
         end
         (cur >= 5'd10 && cur < 5'd20): begin
            tens     = 2'd1;
            tens_x10 = 5'd10;
         end
         default: begin
            tens     = 2'd0;
            tens_x10 = 5'd0;
         end
      endcase
      ones = 4'(cur - tens_x10);
   end

   assign xfer = (state_q != S_IDLE) && char_ready_in;
   assign more = ({1'b0, idx_q} + 3'd1) < {1'b0, cnt_q};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_in) begin
               if (reg_count_in == 2'd0) begin
                  err_d = 1'b1;
               end else begin
                  cnt_d   = reg_count_in;
                  r0_d    = reg0_in;
                  r1_d    = reg1_in;
                  r2_d    = reg2_in;
                  idx_d   = 2'd0;
                  state_d = S_PREFIX;
               end
            end
         end
         S_PREFIX: if (xfer) state_d = S_TENS;
         S_TENS:   if (xfer) state_d = S_ONES;
         S_ONES:   if (xfer) state_d = more ? S_SEP : S_TERM;
         S_SEP: begin
            if (xfer) begin
               idx_d   = idx_q + 2'd1;
               state_d = S_PREFIX;
            end
         end
         S_TERM: begin
            if (xfer) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      char_out = 8'h00;
      unique case (state_q)
         S_PREFIX: char_out = PREFIX_CH;
         S_TENS:   char_out = 8'h30 + {6'd0, tens};
         S_ONES:   char_out = 8'h30 + {4'd0, ones};
         S_SEP:    char_out = SEPARATOR;
         S_TERM:   char_out = TERMINATOR;
         default:  char_out = 8'h00;
      endcase
   end

   assign char_valid_out = (state_q != S_IDLE);
   assign busy_out       = (state_q != S_IDLE);
   assign done_out       = done_q;
   assign error_out      = err_q;

endmodule

// File: tb/tb_register_list_formatter.sv
// Bench for register_list_formatter: random and directed streams checked
// against a text-level model, lowercase and uppercase instances side by side.
module tb_register_list_formatter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] count = 2'd0;
   logic [4:0] reg0 = 5'd0, reg1 = 5'd0, reg2 = 5'd0;
   logic       ready = 1'b0;

   logic       v_lo, b_lo, d_lo, e_lo;
   logic [7:0] c_lo;
   logic       v_up, b_up, d_up, e_up;
   logic [7:0] c_up;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   register_list_formatter #(.UPPERCASE(1'b0)) u_lo (
      .clk_in(clk), .rst_in(rst_n), .start_in(start),
      .reg_count_in(count), .reg0_in(reg0), .reg1_in(reg1), .reg2_in(reg2),
      .char_valid_out(v_lo), .char_out(c_lo), .char_ready_in(ready),
      .busy_out(b_lo), .done_out(d_lo), .error_out(e_lo)
   );

   register_list_formatter #(.UPPERCASE(1'b1)) u_up (
      .clk_in(clk), .rst_in(rst_n), .start_in(start),
      .reg_count_in(count), .reg0_in(reg0), .reg1_in(reg1), .reg2_in(reg2),
      .char_valid_out(v_up), .char_out(c_up), .char_ready_in(ready),
      .busy_out(b_up), .done_out(d_up), .error_out(e_up)
   );

   // Expected text: prefix, two decimal digits, then ',' or ' '.
   function automatic logic [95:0] model(input int cnt, input int a,
                                         input int b, input int c,
                                         input bit up);
      logic [95:0] t;
      int r;
      t = '0;
      for (int i = 0; i < cnt; i++) begin
         r = (i == 0) ? a : (i == 1) ? b : c;
         t = {t[87:0], (up ? 8'h52 : 8'h72)};
         t = {t[87:0], 8'(48 + r / 10)};
         t = {t[87:0], 8'(48 + r % 10)};
         t = {t[87:0], ((i == cnt - 1) ? 8'h20 : 8'h2C)};
      end
      return t;
   endfunction

   logic [95:0] got_lo, got_up;
   int n_lo, n_up, done_lo, done_up, stall_bad;
   int first_k, last_k, done_k;
   bit done_active, timed_out;

   task automatic run_stream(input int cnt, input int a, input int b,
                             input int c, input int mode, input bit mid);
      bit pv, pr, finished;
      logic [7:0] pc;
      got_lo = '0; got_up = '0;
      n_lo = 0; n_up = 0; done_lo = 0; done_up = 0; stall_bad = 0;
      first_k = -1; last_k = -1; done_k = -1;
      done_active = 0; timed_out = 0;
      @(posedge clk); #1;
      count = 2'(cnt); reg0 = 5'(a); reg1 = 5'(b); reg2 = 5'(c);
      start = 1; ready = 0;
      @(posedge clk); #1;
      start = 0;
      pv = 0; pr = 0; pc = 8'h00; finished = 0;
      for (int k = 0; k < 200 && !finished; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         case (mode)
            0:       ready = 1'b1;
            1:       ready = (k % 3 == 0);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         if (mid && k == 3) begin
            start = 1; count = 2'd3;
            reg0 = 5'd31; reg1 = 5'd30; reg2 = 5'd1;
         end
         if (mid && k == 4) start = 0;
         @(negedge clk);
         if (pv && !pr && (!v_lo || c_lo !== pc)) stall_bad++;
         if (v_lo && first_k < 0) first_k = k;
         if (v_lo && ready) begin
            got_lo = {got_lo[87:0], c_lo}; n_lo++; last_k = k;
         end
         if (v_up && ready) begin
            got_up = {got_up[87:0], c_up}; n_up++;
         end
         if (d_lo) begin
            done_lo++; done_k = k;
            if (b_lo || v_lo || b_up || v_up) done_active = 1;
         end
         if (d_up) done_up++;
         if (done_k >= 0 && k > done_k) finished = 1;
         pv = v_lo; pr = ready; pc = c_lo;
      end
      timed_out = !finished;
      @(posedge clk); #1;
      ready = 0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++;
      if ({v_lo, c_lo, b_lo, d_lo, e_lo, v_up, c_up, b_up, d_up, e_up} !== '0)
         $display("FAIL reset_outputs got lo=%b/%h/%b/%b/%b up=%b/%h required all 0",
                  v_lo, c_lo, b_lo, d_lo, e_lo, v_up, c_up);
      else passed++;
   endtask

   task automatic test_two_ops;
      logic [95:0] exp;
      run_stream(2, 5, 17, 0, 0, 0);
      exp = model(2, 5, 17, 0, 0);
      total++;
      if (got_lo !== exp || got_lo[63:0] !== 64'h7230352C72313720)
         $display("FAIL two_ops_text got %h required %h", got_lo, exp);
      else passed++;
      total++;
      if (n_lo !== 8 || first_k !== 0 || last_k !== 7)
         $display("FAIL two_ops_timing got n=%0d first=%0d last=%0d required 8/0/7",
                  n_lo, first_k, last_k);
      else passed++;
      total++;
      if (done_lo !== 1 || done_k !== 8 || done_active || timed_out)
         $display("FAIL two_ops_done got cnt=%0d k=%0d act=%b to=%b required 1/8/0/0",
                  done_lo, done_k, done_active, timed_out);
      else passed++;
   endtask

   task automatic test_uppercase;
      logic [95:0] exp;
      run_stream(3, 0, 30, 31, 0, 0);
      exp = model(3, 0, 30, 31, 1);
      total++;
      if (got_up !== exp || got_up !== 96'h5230302C5233302C52333120 || n_up !== 12)
         $display("FAIL upper_text got %h n=%0d required %h n=12", got_up, n_up, exp);
      else passed++;
      total++;
      if (got_lo !== model(3, 0, 30, 31, 0))
         $display("FAIL lower_three got %h required %h", got_lo, model(3, 0, 30, 31, 0));
      else passed++;
   endtask

   task automatic test_sweep;
      for (int v = 0; v < 32; v++) begin
         run_stream(1, v, 0, 0, 0, 0);
         total++;
         if (got_lo !== model(1, v, 0, 0, 0) || got_up !== model(1, v, 0, 0, 1) ||
             n_lo !== 4 || done_lo !== 1 || timed_out)
            $display("FAIL sweep_v%0d got lo=%h up=%h n=%0d required lo=%h up=%h n=4",
                     v, got_lo[31:0], got_up[31:0], n_lo,
                     model(1, v, 0, 0, 0), model(1, v, 0, 0, 1));
         else passed++;
      end
   endtask

   task automatic test_backpressure;
      run_stream(1, 29, 0, 0, 1, 0);
      total++;
      if (got_lo !== model(1, 29, 0, 0, 0) || got_lo[31:0] !== 32'h72323920 || n_lo !== 4)
         $display("FAIL bp_text got %h n=%0d required 72323920 n=4", got_lo, n_lo);
      else passed++;
      total++;
      if (stall_bad !== 0 || done_lo !== 1)
         $display("FAIL bp_stall got bad=%0d done=%0d required 0/1", stall_bad, done_lo);
      else passed++;
   endtask

   task automatic test_random;
      int cnt, a, b, c;
      for (int i = 0; i < 10; i++) begin
         cnt = $urandom_range(1, 3);
         a = $urandom_range(0, 31);
         b = $urandom_range(0, 31);
         c = $urandom_range(0, 31);
         run_stream(cnt, a, b, c, 2, 0);
         total++;
         if (got_lo !== model(cnt, a, b, c, 0) || got_up !== model(cnt, a, b, c, 1) ||
             n_lo !== 4 * cnt || stall_bad !== 0 || done_lo !== 1 || timed_out)
            $display("FAIL random_%0d got %h n=%0d bad=%0d required %h n=%0d",
                     i, got_lo, n_lo, stall_bad, model(cnt, a, b, c, 0), 4 * cnt);
         else passed++;
      end
   endtask

   task automatic test_error;
      bit busy_seen;
      @(posedge clk); #1;
      count = 2'd0; start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      total++;
      if (e_lo !== 1'b1 || e_up !== 1'b1)
         $display("FAIL error_pulse got %b/%b required 1", e_lo, e_up);
      else passed++;
      busy_seen = b_lo | v_lo;
      @(negedge clk);
      busy_seen = busy_seen | b_lo | v_lo;
      total++;
      if (e_lo !== 1'b0)
         $display("FAIL error_width got %b required 0", e_lo);
      else passed++;
      total++;
      if (busy_seen)
         $display("FAIL error_idle got busy/valid=1 required 0");
      else passed++;
   endtask

   task automatic test_mid_start;
      run_stream(2, 12, 7, 0, 0, 1);
      total++;
      if (got_lo !== model(2, 12, 7, 0, 0) || n_lo !== 8 || done_lo !== 1)
         $display("FAIL mid_start got %h n=%0d done=%0d required %h n=8 done=1",
                  got_lo, n_lo, done_lo, model(2, 12, 7, 0, 0));
      else passed++;
   endtask

   task automatic test_reset_mid;
      int dn;
      @(posedge clk); #1;
      count = 2'd2; reg0 = 5'd14; reg1 = 5'd3; start = 1;
      @(posedge clk); #1;
      start = 0; ready = 1;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      total++;
      if ({v_lo, c_lo, b_lo, d_lo, e_lo} !== '0)
         $display("FAIL reset_async got v=%b c=%h b=%b d=%b e=%b required 0",
                  v_lo, c_lo, b_lo, d_lo, e_lo);
      else passed++;
      ready = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      dn = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (d_lo || v_lo) dn++;
      end
      total++;
      if (dn !== 0)
         $display("FAIL reset_no_done got %0d required 0", dn);
      else passed++;
      run_stream(1, 9, 0, 0, 0, 0);
      total++;
      if (got_lo[31:0] !== 32'h72303920 || n_lo !== 4)
         $display("FAIL reset_restart got %h n=%0d required 72303920 n=4",
                  got_lo[31:0], n_lo);
      else passed++;
   endtask

   task automatic test_back_to_back;
      logic [9:0]  vpat, dpat;
      logic [63:0] got, exp;
      logic [95:0] ma, mb;
      ma = model(1, 3, 0, 0, 0);
      mb = model(1, 22, 0, 0, 0);
      exp = {ma[31:0], mb[31:0]};
      got = '0; vpat = '0; dpat = '0;
      @(posedge clk); #1;
      count = 2'd1; reg0 = 5'd3; start = 1; ready = 1;
      @(posedge clk); #1;
      start = 0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (k == 4) begin
            start = 1; reg0 = 5'd22;
         end
         if (k == 5) start = 0;
         @(negedge clk);
         vpat[k] = v_lo;
         dpat[k] = d_lo;
         if (v_lo && ready) got = {got[55:0], c_lo};
      end
      @(posedge clk); #1;
      ready = 0;
      total++;
      if (got !== exp)
         $display("FAIL b2b_text got %h required %h", got, exp);
      else passed++;
      total++;
      if (vpat !== 10'b0111101111 || dpat !== 10'b1000010000)
         $display("FAIL b2b_timing got v=%b d=%b required 0111101111/1000010000",
                  vpat, dpat);
      else passed++;
   endtask

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk);
      test_reset;
      rst_n = 1;
      test_two_ops;
      test_uppercase;
      test_sweep;
      test_backpressure;
      test_random;
      test_error;
      test_mid_start;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/register_list_formatter.md
Name: register_list_formatter

Overview:
- Inverse of the assembler's register-operand parser. Takes up to three 5-bit register numbers and emits their ASCII text form as a character stream, one byte per valid/ready handshake.
- Example output: "r05,r17,r31 ".
- Sits in the disassembly/echo path, feeding the UART/display character sink.
- Output text is always re-parseable by the assembler front end: two-digit register field, and a "," or " " delimiter after each operand.

Parameters:
- SEPARATOR, default 8'h2C (","), character emitted between operands.
- TERMINATOR, default 8'h20 (" "), character emitted after the last operand.
- UPPERCASE, default 0. 0 = prefix 'r' (8'h72); 1 = prefix 'R' (8'h52).

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, asynchronous active-low reset.
- start_in, input, 1, request to format; sampled only in IDLE.
- reg_count_in, input, 2, number of operands (1..3); 0 is illegal.
- reg0_in, input, 5, first operand.
- reg1_in, input, 5, second operand.
- reg2_in, input, 5, third operand.
- char_valid_out, output, 1, char_out holds a valid byte.
- char_out, output, 8, ASCII byte.
- char_ready_in, input, 1, sink accepts char_out this cycle.
- busy_out, output, 1, a format operation is in progress.
- done_out, output, 1, one-cycle pulse after the final byte is accepted.
- error_out, output, 1, one-cycle pulse on a start request with reg_count_in == 0.

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE.
  - char_valid_out=0, char_out=8'h00, busy_out=0, done_out=0, error_out=0.
  - Internal operand index and captured registers cleared.
  - Reset mid-stream abandons the operation; no done_out pulse is produced.
- States: IDLE, PREFIX, TENS, ONES, SEP, TERM.
- IDLE:
  - On start_in=1 with count != 0: capture reg0..2 and count, set index=0, go to PREFIX.
  - On start_in=1 with count == 0: pulse error_out for one cycle and stay in IDLE.
- start_in while busy_out=1 is ignored. Captured inputs cannot change mid-operation.
- busy_out = (state != IDLE). It rises the cycle after start is accepted.
- char_valid_out = (state in PREFIX, TENS, ONES, SEP, TERM). It is registered, so the first byte appears one cycle after start is sampled.
- Handshake:
  - A byte transfers on a clock edge where char_valid_out && char_ready_in.
  - While char_valid_out=1 and char_ready_in=0, char_out and the state hold stable.
  - char_valid_out never drops without a transfer.
  - With char_ready_in held high, throughput is one byte per cycle.
- Byte per state:
  - PREFIX: 'r' or 'R'.
  - TENS: "0" + tens.
  - ONES: "0" + ones.
  - SEP: SEPARATOR.
  - TERM: TERMINATOR.
- Digit arithmetic on the current register v (0..31):
  - tens = 3 if v>=30, else 2 if v>=20, else 1 if v>=10, else 0.
  - ones = v - 10*tens, 4-bit result, range 0..9.
  - The leading zero is always emitted: v=0 gives "r00".
- Transitions, each taken on a transfer:
  - PREFIX -> TENS -> ONES.
  - ONES -> SEP if index+1 < count, else ONES -> TERM.
  - SEP -> PREFIX with index incremented.
  - TERM -> IDLE.
- On the TERM transfer edge, done_out is registered high for the following cycle only. In that cycle busy_out=0 and char_valid_out=0.
- A new start_in may be sampled in the done_out cycle, giving back-to-back operations with one idle cycle between streams.
- Total bytes emitted = 4*count.
- Count 1: "rDD" followed by TERMINATOR; no SEPARATOR is emitted.

Test Plan:
- Reset, then count=2, reg0=5, reg1=17, ready held 1:
  - Bytes 72,30,35,2C,72,31,37,20 ("r05,r17 ") on 8 consecutive cycles starting 1 cycle after start.
  - done_out pulses once, one cycle after the last byte.
- count=3, regs 0/30/31, UPPERCASE=1:
  - "R00,R30,R31 ", 12 bytes.
  - Exhaustive v=0..31 sweep with count=1: every digit pair decimal-correct.
- Backpressure with ready toggling 1,0,0,1,... during count=1, reg0=29:
  - char_out stable ("2" = 8'h32) through the stall cycles.
  - Sequence "r29 " with no duplicated or dropped byte.
- start_in with count=0:
  - error_out high exactly one cycle.
  - busy_out and char_valid_out stay 0.
- start_in pulsed mid-operation with different regs:
  - Ignored; the original stream completes unchanged.
- rst_in asserted low after the second byte:
  - All outputs 0 immediately (asynchronous, before the next edge); no done_out pulse.
  - After release, a fresh start for reg0=9 yields "r09 ".
